// File: rtl/mfp_ahb_lite_cmd_master.sv
// mfp_ahb_lite_cmd_master: command stream to pipelined AHB-Lite SINGLE transfers; MFP_AHB_MASTER_HRESP_EN enables two-cycle error handling
module mfp_ahb_lite_cmd_master #(
  parameter logic [3:0] HPROT_VALUE = 4'b0011
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [2:0]  HSIZE,
  output logic [1:0]  HTRANS,
  output logic [31:0] HWDATA,
  output logic        HWRITE,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);
`ifdef MFP_AHB_MASTER_HRESP_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif
  typedef enum logic {EMPTY, FULL} stage_t;
  stage_t a_st, d_st;
  logic a_write, d_write, a_valid, d_valid, accept, err_now, err_st, c_pend, c_fire;
  logic [31:0] a_addr, a_wdata, d_wdata, al_addr;
  logic [2:0] a_size, sz;
  assign a_valid = a_st == FULL;
  assign d_valid = d_st == FULL;
  // first error cycle: the failing data phase stalls while HRESP is already high
  assign err_now = ERR_EN & d_valid & HRESP & ~HREADY;
  assign cmd_ready = ~HRESET & (~a_valid | HREADY) & ~err_now & ~err_st;
  assign accept = cmd_valid & cmd_ready;
  assign sz = cmd_size > 3'd2 ? 3'd2 : cmd_size;
  assign al_addr = sz == 3'd1 ? {cmd_addr[31:1], 1'b0} : sz == 3'd2 ? {cmd_addr[31:2], 2'b00} : cmd_addr;
  assign HTRANS = a_valid ? 2'b10 : 2'b00;
  assign HADDR = a_addr;
  assign HWRITE = a_write;
  assign HSIZE = a_size;
  assign HWDATA = d_wdata;
  assign HBURST = 3'b000;
  assign HMASTLOCK = 1'b0;
  assign HPROT = HPROT_VALUE;
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      a_st <= EMPTY;
      d_st <= EMPTY;
      a_write <= 1'b0;
      a_addr <= 32'd0;
      a_size <= 3'd2;
      a_wdata <= 32'd0;
      d_write <= 1'b0;
      d_wdata <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err <= 1'b0;
      err_st <= 1'b0;
      c_pend <= 1'b0;
      c_fire <= 1'b0;
    end else begin
      rsp_valid <= (d_valid & HREADY) | c_fire;
      rsp_rdata <= (d_valid & HREADY & ~d_write) ? HRDATA : 32'd0;
      rsp_err <= c_fire | (ERR_EN & d_valid & HREADY & HRESP);
      c_fire <= c_pend & HREADY;
      err_st <= err_now | (err_st & ~HREADY);
      // a cancelled command is never issued but still owes an error response
      if (err_now & a_valid) begin
        a_st <= EMPTY;
        c_pend <= 1'b1;
      end else if (HREADY | ~a_valid) begin
        a_st <= accept ? FULL : EMPTY;
        if (accept) begin
          a_write <= cmd_write;
          a_addr <= al_addr;
          a_size <= sz;
          a_wdata <= cmd_wdata;
        end
      end
      if (HREADY) begin
        c_pend <= 1'b0;
        d_st <= a_st;
        d_write <= a_write;
        d_wdata <= a_wdata;
      end
    end
  end
endmodule
